cpu4_wbck: RTL and testbench

Writeback stage of the cpu4 core, directly upstream of the integer register file. It arbitrates between the single-cycle ALU result path and the long-latency load/store unit (LSU) return path, and registers the winning result into a one-cycle write port (rd_wen/rd_idx/rd_data) that drives the register file. It also holds the load scoreboard, a per-register pending bit that decode uses to stall on outstanding loads.

---
 rtl/cpu4_wbck_pkg.sv | 21 ++
 rtl/sirv_gnrl_dfflr.sv | 22 ++
 rtl/cpu4_wbck.sv | 121 ++++++++++++
 tb/tb_cpu4_wbck.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu4_wbck_pkg.sv
// Shared widths and types for the cpu4 writeback stage.
package cpu4_wbck_pkg;

  localparam int XLEN      = 32;
  localparam int RFIDX_W   = 5;
  localparam int RFREG_NUM = 32;

  // Which source owns the write port in a given cycle.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  // One register-file write as carried by the output register.
  typedef struct packed {
    logic               wen;
    logic [RFIDX_W-1:0] idx;
    logic [XLEN-1:0]    data;
  } wb_rec_t;

endpackage

// File: rtl/sirv_gnrl_dfflr.sv
// General load-enabled flop with asynchronous active-low reset to zero.
module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  // Capture dnxt on enabled edges; clear immediately on reset.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/cpu4_wbck.sv
// cpu4 writeback stage: LSU-priority arbitration into a registered
// register-file write port, plus the outstanding-load scoreboard.
module cpu4_wbck
  import cpu4_wbck_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_wb_valid,
  output logic                 alu_wb_ready,
  input  logic                 alu_wb_en,
  input  logic [RFIDX_W-1:0]   alu_wb_idx,
  input  logic [XLEN-1:0]      alu_wb_data,
  input  logic                 lsu_wb_valid,
  output logic                 lsu_wb_ready,
  input  logic                 lsu_wb_err,
  input  logic [RFIDX_W-1:0]   lsu_wb_idx,
  input  logic [XLEN-1:0]      lsu_wb_data,
  input  logic                 ld_iss_valid,
  input  logic [RFIDX_W-1:0]   ld_iss_idx,
  output logic [RFREG_NUM-1:0] pend_vec,
  output logic                 ld_idle,
  output logic                 ld_err,
  output logic                 rd_wen,
  output logic [RFIDX_W-1:0]   rd_idx,
  output logic [XLEN-1:0]      rd_data
);

  wb_src_e              src;
  logic                 lsu_fire;
  logic                 alu_fire;
  logic                 wr;
  logic [RFIDX_W-1:0]   sel_idx;
  logic [XLEN-1:0]      sel_data;
  wb_rec_t              rd_q;
  wb_rec_t              rd_nxt;
  logic [RFREG_NUM-1:0] pend_set;
  logic [RFREG_NUM-1:0] pend_clr;
  logic [RFREG_NUM-1:0] pend_nxt;
  logic                 ld_err_nxt;

  // The LSU cannot be stalled, so it always wins and the ALU waits.
  assign lsu_wb_ready = 1'b1;
  assign alu_wb_ready = ~lsu_wb_valid;
  assign lsu_fire     = lsu_wb_valid;
  assign alu_fire     = alu_wb_valid & alu_wb_ready;
  assign src          = lsu_wb_valid ? WB_SRC_LSU : WB_SRC_ALU;

  // Select the winner's destination/data and qualify the write (x0 is never written).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_idx  = alu_wb_idx;
    sel_data = alu_wb_data;
    wr       = 1'b0;
    unique case (src)
      WB_SRC_LSU: begin
        sel_idx  = lsu_wb_idx;
        sel_data = lsu_wb_data;
        wr       = lsu_fire & ~lsu_wb_err;
      end
      WB_SRC_ALU: begin
        wr       = alu_fire & alu_wb_en;
      end
      default: ;
    endcase
    if (sel_idx == '0) wr = 1'b0;
  end

  // Write enable follows wr every cycle; index/data hold when nothing is written.
  assign rd_nxt = wr ? '{wen: 1'b1, idx: sel_idx, data: sel_data}
                     : '{wen: 1'b0, idx: rd_q.idx, data: rd_q.data};

  sirv_gnrl_dfflr #(.DW($bits(wb_rec_t))) u_rd_reg (
    .clk   (clk),
    .rst_n (rst),
    .lden  (1'b1),
    .dnxt  (rd_nxt),
    .qout  (rd_q)
  );

  assign rd_wen  = rd_q.wen;
  assign rd_idx  = rd_q.idx;
  assign rd_data = rd_q.data;

  // Per-register scoreboard bit: issue sets, return clears, set wins on a tie.
  for (genvar i = 0; i < RFREG_NUM; i++) begin : g_pend
    assign pend_set[i] = ld_iss_valid & (ld_iss_idx == RFIDX_W'(i)) & (i != 0);
    assign pend_clr[i] = lsu_fire & (lsu_wb_idx == RFIDX_W'(i));
    assign pend_nxt[i] = pend_set[i] | (pend_vec[i] & ~pend_clr[i]);
  end

  sirv_gnrl_dfflr #(.DW(RFREG_NUM)) u_pend_reg (
    .clk   (clk),
    .rst_n (rst),
    .lden  (ld_iss_valid | lsu_fire),
    .dnxt  (pend_nxt),
    .qout  (pend_vec)
  );

  assign ld_idle = (pend_vec == '0);

  // Faulted-load retirement pulse.
  assign ld_err_nxt = lsu_fire & lsu_wb_err;

  sirv_gnrl_dfflr #(.DW(1)) u_ld_err_reg (
    .clk   (clk),
    .rst_n (rst),
    .lden  (1'b1),
    .dnxt  (ld_err_nxt),
    .qout  (ld_err)
  );

  // Decode must not issue onto a pending register unless it retires this same cycle.
  a_issue_pending : assert property (@(posedge clk) disable iff (!rst)
    (ld_iss_valid && ld_iss_idx != '0) |->
      (!pend_vec[ld_iss_idx] || (lsu_fire && lsu_wb_idx == ld_iss_idx)));

  // A load return must match an outstanding load (x0 returns carry no scoreboard bit).
  a_return_unpending : assert property (@(posedge clk) disable iff (!rst)
    (lsu_fire && lsu_wb_idx != '0) |-> pend_vec[lsu_wb_idx]);

endmodule

// File: tb/tb_cpu4_wbck.sv
// Self-checking bench for cpu4_wbck: directed scenarios with literal
// expectations plus constrained-random traffic against a behavioural model.
module tb_cpu4_wbck;
  import cpu4_wbck_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 alu_wb_valid = 1'b0;
  logic                 alu_wb_ready;
  logic                 alu_wb_en = 1'b0;
  logic [RFIDX_W-1:0]   alu_wb_idx = '0;
  logic [XLEN-1:0]      alu_wb_data = '0;
  logic                 lsu_wb_valid = 1'b0;
  logic                 lsu_wb_ready;
  logic                 lsu_wb_err = 1'b0;
  logic [RFIDX_W-1:0]   lsu_wb_idx = '0;
  logic [XLEN-1:0]      lsu_wb_data = '0;
  logic                 ld_iss_valid = 1'b0;
  logic [RFIDX_W-1:0]   ld_iss_idx = '0;
  logic [RFREG_NUM-1:0] pend_vec;
  logic                 ld_idle;
  logic                 ld_err;
  logic                 rd_wen;
  logic [RFIDX_W-1:0]   rd_idx;
  logic [XLEN-1:0]      rd_data;

  int n_cmp = 0;
  int n_err = 0;

  cpu4_wbck dut (
    .clk          (clk),
    .rst          (rst),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_en    (alu_wb_en),
    .alu_wb_idx   (alu_wb_idx),
    .alu_wb_data  (alu_wb_data),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_ready (lsu_wb_ready),
    .lsu_wb_err   (lsu_wb_err),
    .lsu_wb_idx   (lsu_wb_idx),
    .lsu_wb_data  (lsu_wb_data),
    .ld_iss_valid (ld_iss_valid),
    .ld_iss_idx   (ld_iss_idx),
    .pend_vec     (pend_vec),
    .ld_idle      (ld_idle),
    .ld_err       (ld_err),
    .rd_wen       (rd_wen),
    .rd_idx       (rd_idx),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the register-file port and scoreboard must show
  // after each edge, derived from the arbitration and scoreboard rules.
  logic                 m_wen;
  logic [RFIDX_W-1:0]   m_idx;
  logic [XLEN-1:0]      m_data;
  logic [RFREG_NUM-1:0] m_pend;
  logic                 m_err;

  function automatic logic [RFREG_NUM-1:0] next_pend(input logic [RFREG_NUM-1:0] p);
    logic [RFREG_NUM-1:0] r;
    r = p;
    if (lsu_wb_valid) r[lsu_wb_idx] = 1'b0;
    if (ld_iss_valid && ld_iss_idx != 0) r[ld_iss_idx] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wen  <= 1'b0;
      m_idx  <= '0;
      m_data <= '0;
      m_pend <= '0;
      m_err  <= 1'b0;
    end else begin
      m_err  <= lsu_wb_valid && lsu_wb_err;
      m_pend <= next_pend(m_pend);
      if (lsu_wb_valid) begin
        m_wen <= !lsu_wb_err && lsu_wb_idx != 0;
        if (!lsu_wb_err && lsu_wb_idx != 0) begin
          m_idx  <= lsu_wb_idx;
          m_data <= lsu_wb_data;
        end
      end else if (alu_wb_valid && alu_wb_en && alu_wb_idx != 0) begin
        m_wen  <= 1'b1;
        m_idx  <= alu_wb_idx;
        m_data <= alu_wb_data;
      end else begin
        m_wen <= 1'b0;
      end
    end
  end

  // Compare process: every falling edge out of reset, DUT against model.
  always @(negedge clk) begin
    if (rst) begin
      check("m_rd_wen",  64'(rd_wen),       64'(m_wen));
      check("m_rd_idx",  64'(rd_idx),       64'(m_idx));
      check("m_rd_data", 64'(rd_data),      64'(m_data));
      check("m_pend",    64'(pend_vec),     64'(m_pend));
      check("m_ld_idle", 64'(ld_idle),      64'(m_pend == '0));
      check("m_ld_err",  64'(ld_err),       64'(m_err));
      check("m_alu_rdy", 64'(alu_wb_ready), 64'(!lsu_wb_valid));
      check("m_lsu_rdy", 64'(lsu_wb_ready), 64'd1);
    end
  end

  task automatic idle();
    alu_wb_valid = 1'b0; alu_wb_en = 1'b0; alu_wb_idx = '0; alu_wb_data = '0;
    lsu_wb_valid = 1'b0; lsu_wb_err = 1'b0; lsu_wb_idx = '0; lsu_wb_data = '0;
    ld_iss_valid = 1'b0; ld_iss_idx = '0;
  endtask

  // Advance across one rising edge and land just after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int idx);
    ld_iss_valid = 1'b1;
    ld_iss_idx   = RFIDX_W'(idx);
  endtask

  task automatic lsu_ret(input int idx, input logic err, input logic [XLEN-1:0] data);
    lsu_wb_valid = 1'b1;
    lsu_wb_err   = err;
    lsu_wb_idx   = RFIDX_W'(idx);
    lsu_wb_data  = data;
  endtask

  task automatic alu(input int idx, input logic en, input logic [XLEN-1:0] data);
    alu_wb_valid = 1'b1;
    alu_wb_en    = en;
    alu_wb_idx   = RFIDX_W'(idx);
    alu_wb_data  = data;
  endtask

  initial begin
    logic alu_hold;
    int   pq[$];
    int   idx;

    // Reset values.
    #12 rst = 1'b1;
    #1;
    check("rst_rd_wen",  64'(rd_wen),   64'd0);
    check("rst_rd_idx",  64'(rd_idx),   64'd0);
    check("rst_rd_data", 64'(rd_data),  64'd0);
    check("rst_pend",    64'(pend_vec), 64'd0);
    check("rst_ld_idle", 64'(ld_idle),  64'd1);
    check("rst_ld_err",  64'(ld_err),   64'd0);
    tick();

    // ALU only.
    alu(5, 1'b1, 32'h1234_5678);
    #1 check("alu_ready", 64'(alu_wb_ready), 64'd1);
    tick(); idle();
    check("alu_wen",  64'(rd_wen),  64'd1);
    check("alu_idx",  64'(rd_idx),  64'd5);
    check("alu_data", 64'(rd_data), 64'h1234_5678);
    tick();
    check("alu_wen_off", 64'(rd_wen), 64'd0);
    check("alu_idx_hold", 64'(rd_idx), 64'd5);

    // Conflict: LSU x7 beats ALU x3, ALU lands one cycle later.
    issue(7); tick(); idle();
    check("cf_pend7", 64'(pend_vec), 64'h80);
    alu(3, 1'b1, 32'hA5A5_0003);
    lsu_ret(7, 1'b0, 32'hCAFE_0000);
    #1 check("cf_alu_ready", 64'(alu_wb_ready), 64'd0);
    tick();
    lsu_wb_valid = 1'b0;
    check("cf_lsu_wen",  64'(rd_wen),  64'd1);
    check("cf_lsu_idx",  64'(rd_idx),  64'd7);
    check("cf_lsu_data", 64'(rd_data), 64'hCAFE_0000);
    #1 check("cf_alu_ready2", 64'(alu_wb_ready), 64'd1);
    tick(); idle();
    check("cf_alu_idx",  64'(rd_idx),  64'd3);
    check("cf_alu_data", 64'(rd_data), 64'hA5A5_0003);

    // Scoreboard set and clear on x9.
    issue(9); tick(); idle();
    check("sb_pend9", 64'(pend_vec), 64'h200);
    check("sb_busy",  64'(ld_idle),  64'd0);
    lsu_ret(9, 1'b0, 32'h0000_0099); tick(); idle();
    check("sb_wen9", 64'(rd_wen),   64'd1);
    check("sb_idx9", 64'(rd_idx),   64'd9);
    check("sb_clr9", 64'(pend_vec), 64'd0);
    check("sb_idle", 64'(ld_idle),  64'd1);

    // Same-cycle set and clear on x4: set wins.
    issue(4); tick(); idle();
    lsu_ret(4, 1'b0, 32'h0000_0044); issue(4); tick(); idle();
    check("sc_pend4", 64'(pend_vec), 64'h10);
    check("sc_idx4",  64'(rd_idx),   64'd4);
    lsu_ret(4, 1'b0, 32'h0000_0045); tick(); idle();
    check("sc_clr4", 64'(pend_vec), 64'd0);

    // Faulted load on x6, then an ALU write to x0.
    issue(6); tick(); idle();
    lsu_ret(6, 1'b1, 32'hDEAD_BEEF); tick(); idle();
    check("er_wen",   64'(rd_wen),   64'd0);
    check("er_pend",  64'(pend_vec), 64'd0);
    check("er_pulse", 64'(ld_err),   64'd1);
    check("er_hold",  64'(rd_data),  64'h0000_0045);
    alu(0, 1'b1, 32'hFFFF_FFFF); tick(); idle();
    check("er_pulse_end", 64'(ld_err), 64'd0);
    check("x0_wen",       64'(rd_wen), 64'd0);

    // Asynchronous reset with loads outstanding and a write in flight.
    issue(2); tick(); idle();
    issue(9); alu(1, 1'b1, 32'h0000_0011); tick(); idle();
    check("ar_pend_pre", 64'(pend_vec), 64'h204);
    check("ar_wen_pre",  64'(rd_wen),   64'd1);
    #2 rst = 1'b0;
    #1;
    check("ar_wen",  64'(rd_wen),   64'd0);
    check("ar_idx",  64'(rd_idx),   64'd0);
    check("ar_data", 64'(rd_data),  64'd0);
    check("ar_pend", 64'(pend_vec), 64'd0);
    check("ar_idle", 64'(ld_idle),  64'd1);
    check("ar_err",  64'(ld_err),   64'd0);
    @(negedge clk); rst = 1'b1; #1;

    // Random legal traffic, compared every cycle by the model process.
    alu_hold = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        rst = 1'b0; #2 rst = 1'b1;
        idle();
        alu_hold = 1'b0;
      end
      lsu_wb_valid = 1'b0; lsu_wb_err = 1'b0;
      ld_iss_valid = 1'b0;
      pq.delete();
      for (int i = 1; i < RFREG_NUM; i++) if (m_pend[i]) pq.push_back(i);
      if (pq.size() > 0 && $urandom_range(0, 2) == 0)
        lsu_ret(pq[$urandom_range(0, pq.size() - 1)], ($urandom_range(0, 4) == 0), $urandom);
      else if ($urandom_range(0, 19) == 0)
        lsu_ret(0, ($urandom_range(0, 1) == 1), $urandom);
      if ($urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, RFREG_NUM - 1);
        if (lsu_wb_valid && $urandom_range(0, 3) == 0) idx = int'(lsu_wb_idx);
        if (idx == 0 || !m_pend[idx] || (lsu_wb_valid && int'(lsu_wb_idx) == idx))
          issue(idx);
      end
      if (!alu_hold) begin
        if ($urandom_range(0, 3) != 0)
          alu($urandom_range(0, RFREG_NUM - 1), ($urandom_range(0, 3) != 0), $urandom);
        else
          alu_wb_valid = 1'b0;
      end
      alu_hold = alu_wb_valid && lsu_wb_valid;
      tick();
    end
    idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
